pinput_dchain_extmode_array: RTL and testbench

- Multi-channel, configurable pad-input tile. It generalises the single-channel pinput_dchain_extmode and its feedthrough mode memory into NUM_CH channels.
- Each channel takes its own MODE_W-bit mode word from an internal configuration-chain shift register. The word is double-buffered: shift register, then active register.
- Each channel conditions its SoC-side pad input before driving the fabric:
  - optional inversion;
  - optional 2-FF synchroniser;
  - optional glitch filter;
  - level or rising-edge-pulse output.
- Sits between the pad ring (soc_in_i) and the FPGA fabric (fpga_in_o), in place of the per-pad logical tiles.

---
 rtl/pinput_dchain_extmode_array_if.sv | 19 +
 rtl/pinput_dchain_extmode_array.sv | 67 ++++++
 tb/tb_pinput_dchain_extmode_array.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pinput_dchain_extmode_array_if.sv
// pinput_dchain_extmode_array_if: configuration chain and pad/fabric signals of the pad-input tile
interface pinput_dchain_extmode_array_if #(
   parameter int NUM_CH = 4
);
   logic              config_enable;
   logic              ccff_head;
   logic              ccff_tail;
   logic [NUM_CH-1:0] soc_in_i;
   logic [NUM_CH-1:0] fpga_in_o;
   logic [NUM_CH-1:0] mode_o;
   modport master (
      output config_enable, ccff_head, soc_in_i,
      input  ccff_tail, fpga_in_o, mode_o
   );
   modport slave (
      input  config_enable, ccff_head, soc_in_i,
      output ccff_tail, fpga_in_o, mode_o
   );
endinterface

// File: rtl/pinput_dchain_extmode_array.sv
// pinput_dchain_extmode_array: multi-channel pad-input tile with a double-buffered mode chain
module pinput_dchain_extmode_array #(
   parameter int NUM_CH   = 4,
   parameter int MODE_W   = 5,
   parameter int FILT_W   = 4,
   parameter int FILT_LEN = 7
) (
   input logic                            clk,
   input logic                            reset,
   pinput_dchain_extmode_array_if.slave   bus
);
   localparam int TOTAL = NUM_CH * MODE_W;
   logic [TOTAL-1:0] r_chain;
   logic [TOTAL-1:0] r_active;
   logic             r_cfg_d;
   logic             w_load;
   // the active word is taken one cycle after the last shift, when config_enable falls
   assign w_load        = r_cfg_d & ~bus.config_enable;
   assign bus.ccff_tail = r_chain[TOTAL-1];
   always_ff @(posedge clk) begin
      if (reset) begin
         r_chain  <= '0;
         r_active <= '0;
         r_cfg_d  <= 1'b0;
      end else begin
         if (bus.config_enable) r_chain <= {r_chain[TOTAL-2:0], bus.ccff_head};
         if (w_load) r_active <= r_chain;
         r_cfg_d <= bus.config_enable;
      end
   end
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [MODE_W-1:0] w_mode;
      logic              w_cand;
      logic              r_s0, r_s1, r_s2, r_filt, r_prev;
      logic [FILT_W-1:0] r_cnt;
      assign w_mode = r_active[c*MODE_W +: MODE_W];
      assign w_cand = w_mode[2] ? r_s2 : r_s0;
      always_ff @(posedge clk) begin
         if (reset || w_load) begin
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_filt <= 1'b0;
            r_prev <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_s0   <= bus.soc_in_i[c] ^ w_mode[1];
            r_s1   <= r_s0;
            r_s2   <= r_s1;
            r_prev <= r_filt;
            if (!w_mode[3]) begin
               r_filt <= w_cand;
               r_cnt  <= '0;
            end else if (w_cand == r_filt) begin
               r_cnt <= '0;
            end else if (r_cnt == FILT_W'(FILT_LEN - 1)) begin
               r_filt <= w_cand;
               r_cnt  <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
      assign bus.fpga_in_o[c] = w_mode[0] & r_filt & ~(w_mode[4] & r_prev);
      assign bus.mode_o[c]    = w_mode[0];
   end
endmodule

// File: tb/tb_pinput_dchain_extmode_array.sv
// tb_pinput_dchain_extmode_array: vector table, corner sequences and random run against a behavioural model
module tb_pinput_dchain_extmode_array;
   localparam int NC = 4, MW = 5, FL = 7, TOT = NC * MW;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   pinput_dchain_extmode_array_if #(.NUM_CH(NC)) bus();
   pinput_dchain_extmode_array #(.NUM_CH(NC), .MODE_W(MW), .FILT_W(4), .FILT_LEN(FL)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   int tests = 0, fails = 0;
   // model: shifted-in bit history, active mode words, sampled-input history, filtered level and run length
   bit          cq[$];
   bit          m_cfg_d;
   logic [MW-1:0] m_act[NC];
   bit          m_filt[NC], m_prev[NC];
   int          m_run[NC];
   bit          m_hist[NC][$];
   function automatic bit chain_bit(int i);
      return (i < cq.size()) ? cq[cq.size()-1-i] : 1'b0;
   endfunction
   task automatic model_edge();
      bit load, cand;
      int k;
      if (reset) begin
         cq.delete();
         m_cfg_d = 0;
         for (int c = 0; c < NC; c++) begin
            m_act[c] = '0; m_filt[c] = 0; m_prev[c] = 0; m_run[c] = 0; m_hist[c].delete();
         end
         return;
      end
      load = m_cfg_d && !bus.config_enable;
      for (int c = 0; c < NC; c++) begin
         if (load) begin
            m_filt[c] = 0; m_prev[c] = 0; m_run[c] = 0; m_hist[c].delete();
         end else begin
            k = m_act[c][2] ? 3 : 1;
            cand = (m_hist[c].size() >= k) ? m_hist[c][k-1] : 1'b0;
            m_hist[c].push_front(bus.soc_in_i[c] ^ m_act[c][1]);
            if (m_hist[c].size() > 3) void'(m_hist[c].pop_back());
            m_prev[c] = m_filt[c];
            if (!m_act[c][3]) begin
               m_filt[c] = cand; m_run[c] = 0;
            end else if (cand == m_filt[c]) m_run[c] = 0;
            else if (m_run[c] + 1 >= FL) begin
               m_filt[c] = cand; m_run[c] = 0;
            end else m_run[c]++;
         end
      end
      if (load)
         for (int c = 0; c < NC; c++)
            for (int b = 0; b < MW; b++) m_act[c][b] = chain_bit(c*MW + b);
      if (bus.config_enable) begin
         cq.push_back(bus.ccff_head);
         if (cq.size() > TOT) void'(cq.pop_front());
      end
      m_cfg_d = bus.config_enable;
   endtask
   function automatic logic [NC-1:0] exp_fpga();
      logic [NC-1:0] r = '0;
      for (int c = 0; c < NC; c++)
         r[c] = m_act[c][0] && m_filt[c] && !(m_act[c][4] && m_prev[c]);
      return r;
   endfunction
   function automatic logic [NC-1:0] exp_mode();
      logic [NC-1:0] r = '0;
      for (int c = 0; c < NC; c++) r[c] = m_act[c][0];
      return r;
   endfunction
   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("model_fpga", 32'(bus.fpga_in_o), 32'(exp_fpga()));
      check("model_mode", 32'(bus.mode_o), 32'(exp_mode()));
      check("model_tail", 32'(bus.ccff_tail), 32'(cq.size() == TOT ? cq[0] : 1'b0));
   endtask
   task automatic shift_cfg(input logic [TOT-1:0] w);
      for (int i = TOT-1; i >= 0; i--) begin
         bus.config_enable = 1'b1; bus.ccff_head = w[i]; tick();
      end
      bus.config_enable = 1'b0; bus.ccff_head = 1'b0; tick();
   endtask
   typedef struct {
      logic [TOT-1:0] word;
      logic [NC-1:0]  soc;
      logic [NC-1:0]  exp_mode;
      logic [NC-1:0]  exp_fpga;
   } vec_t;
   vec_t vt[5];
   logic [31:0] rw;
   initial begin
      vt[0] = '{{4{5'b00001}}, 4'b0101, 4'b1111, 4'b0101};
      vt[1] = '{{4{5'b00011}}, 4'b0101, 4'b1111, 4'b1010};
      vt[2] = '{{5'b00000, 5'b10011, 5'b01101, 5'b00001}, 4'b1011, 4'b0111, 4'b0011};
      vt[3] = '{{4{5'b00000}}, 4'b1111, 4'b0000, 4'b0000};
      vt[4] = '{{4{5'b00111}}, 4'b0011, 4'b1111, 4'b1100};
      reset = 1'b1; bus.config_enable = 1'b0; bus.ccff_head = 1'b0; bus.soc_in_i = 4'hF;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_fpga", 32'(bus.fpga_in_o), 0);
      check("rst_mode", 32'(bus.mode_o), 0);
      check("rst_tail", 32'(bus.ccff_tail), 0);
      foreach (vt[i]) begin
         bus.soc_in_i = vt[i].soc;
         shift_cfg(vt[i].word);
         repeat (20) tick();
         check("vec_mode", 32'(bus.mode_o), 32'(vt[i].exp_mode));
         check("vec_fpga", 32'(bus.fpga_in_o), 32'(vt[i].exp_fpga));
      end
      // ch0 plain, ch1 sync+filter, ch2 inverted edge
      bus.soc_in_i = 4'b0100;
      shift_cfg({5'b00000, 5'b10011, 5'b01101, 5'b00001});
      check("load_mode", 32'(bus.mode_o), 32'h7);
      repeat (10) tick();
      bus.soc_in_i[0] = 1'b1;
      tick(); check("lat2_e1", 32'(bus.fpga_in_o[0]), 0);
      tick(); check("lat2_e2", 32'(bus.fpga_in_o[0]), 1);
      bus.soc_in_i[1] = 1'b1; repeat (6) tick(); bus.soc_in_i[1] = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(); check("short_pulse", 32'(bus.fpga_in_o[1]), 0);
      end
      bus.soc_in_i[1] = 1'b1;
      repeat (9) tick(); check("filt_e9", 32'(bus.fpga_in_o[1]), 0);
      tick(); check("filt_e10", 32'(bus.fpga_in_o[1]), 1);
      bus.soc_in_i[2] = 1'b0;
      tick(); check("edge_e1", 32'(bus.fpga_in_o[2]), 0);
      tick(); check("edge_e2", 32'(bus.fpga_in_o[2]), 1);
      tick(); check("edge_e3", 32'(bus.fpga_in_o[2]), 0);
      bus.soc_in_i[2] = 1'b1;
      repeat (5) begin
         tick(); check("edge_rise", 32'(bus.fpga_in_o[2]), 0);
      end
      // reconfigure ch0 to sync mode while it is running
      for (int i = TOT-1; i >= 0; i--) begin
         rw = {12'd0, 20'b00000_00000_00000_00101};
         bus.config_enable = 1'b1; bus.ccff_head = rw[i]; tick();
         check("old_mode_hold", 32'(bus.fpga_in_o[0]), 1);
      end
      bus.config_enable = 1'b0; tick();
      check("reload_clear", 32'(bus.fpga_in_o[0]), 0);
      repeat (3) tick(); check("sync_e3", 32'(bus.fpga_in_o[0]), 0);
      tick(); check("sync_e4", 32'(bus.fpga_in_o[0]), 1);
      // reset mid-shift
      for (int i = 0; i < 10; i++) begin
         bus.config_enable = 1'b1; bus.ccff_head = 1'b1; tick();
      end
      reset = 1'b1; tick();
      check("rst_shift_mode", 32'(bus.mode_o), 0);
      check("rst_shift_tail", 32'(bus.ccff_tail), 0);
      reset = 1'b0; bus.config_enable = 1'b0; tick();
      check("no_load_after_rst", 32'(bus.mode_o), 0);
      // reset mid-filter count
      bus.soc_in_i = 4'b0000;
      shift_cfg({5'b00000, 5'b00000, 5'b01001, 5'b00000});
      repeat (5) tick();
      bus.soc_in_i[1] = 1'b1; repeat (5) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst_filt_fpga", 32'(bus.fpga_in_o), 0);
      check("rst_filt_mode", 32'(bus.mode_o), 0);
      // random traffic with random modes, config glitches and occasional resets
      for (int seg = 0; seg < 12; seg++) begin
         rw = $urandom();
         shift_cfg(rw[TOT-1:0]);
         for (int i = 0; i < 200; i++) begin
            for (int c = 0; c < NC; c++)
               if ($urandom_range(0, 3) == 0) bus.soc_in_i[c] = ~bus.soc_in_i[c];
            bus.config_enable = ($urandom_range(0, 59) == 0);
            bus.ccff_head = 1'($urandom());
            reset = ($urandom_range(0, 299) == 0);
            tick();
         end
         reset = 1'b0; bus.config_enable = 1'b0;
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
